// File: rtl/com_to_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : com_to_fifo_if                                             |
// | Description : FIFO-side handshake bundle of the serial-to-FIFO receiver: |
// |               write strobe and byte from the receiver, busy/full status  |
// |               back from the FIFO.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface com_to_fifo_if;
    logic       fifo_we;
    logic [7:0] forSent;
    logic       fifo_busy;
    logic       fifo_full;

    // Receiver side: produces writes, observes FIFO status.
    modport master (
        output fifo_we,
        output forSent,
        input  fifo_busy,
        input  fifo_full
    );

    // FIFO side: consumes writes, reports its status.
    modport slave (
        input  fifo_we,
        input  forSent,
        output fifo_busy,
        output fifo_full
    );
endinterface
`default_nettype wire

// File: rtl/com_to_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : com_to_fifo                                                |
// | Description : UART receiver that takes bytes in {data, CRC-8} pairs,     |
// |               verifies the CRC (poly 0x07, init 0x00) and writes good    |
// |               data bytes into a FIFO. Sticky error flags                 |
// |               {overrun, crc, parity, frame}.                             |
// |               Optional macro COM_RX_PARITY_EN adds an even-parity bit    |
// |               after bit 7 (8E1); undefined gives plain 8N1.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module com_to_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_BITS     = 255
) (
    input  wire           clk,
    input  wire           reset,
    input  wire           enable,
    input  wire           rx,
    com_to_fifo_if.master fifo,
    output logic          isFinish,
    output logic [3:0]    error
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(GAP_LIMIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5,
        WRITE  = 3'd6
    } state_t;

    state_t           state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [2:0]       sync_vld;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [7:0]       data_byte;
    logic [7:0]       last_sent;
    logic             phase;
    logic [GAP_W-1:0] gap_cnt;
    logic             err_ovr;
    logic             err_crc;
    logic             err_par;
    logic             err_frm;
`ifdef COM_RX_PARITY_EN
    logic             par_bad;
`endif

    logic fall;
    logic crc_ok;
    logic wr_ok;

    // CRC-8, poly x^8+x^2+x+1, init 0, MSB first, no reflection, no final xor.
    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    // sync_vld marks when rx_sync/rx_prev hold real line samples, so a line
    // that is already low when reset releases never looks like a fresh edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            sync_vld <= 3'b000;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            sync_vld <= {sync_vld[1:0], 1'b1};
        end
    end

    assign fall   = sync_vld[2] & rx_prev & ~rx_sync;
    assign crc_ok = (crc8(data_byte) == shreg);

    // The write strobe follows fifo_busy combinationally so the FIFO sees the
    // write in the very first cycle it is free.
    assign wr_ok        = (state == WRITE) && !fifo.fifo_busy && !fifo.fifo_full;
    assign fifo.fifo_we = wr_ok;
    assign isFinish     = wr_ok;
    assign fifo.forSent = wr_ok ? data_byte : last_sent;

`ifndef COM_RX_PARITY_EN
    assign err_par = 1'b0;
`endif

    assign error = {err_ovr, err_crc, err_par, err_frm};

    // Receive FSM: bit timing, pair phase, gap timeout, CRC check, FIFO write.
    // Flags are only cleared in START and only set in other states, so a set
    // can never be lost to a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            data_byte <= 8'h00;
            last_sent <= 8'h00;
            phase     <= 1'b0;
            gap_cnt   <= '0;
            err_ovr   <= 1'b0;
            err_crc   <= 1'b0;
            err_frm   <= 1'b0;
`ifdef COM_RX_PARITY_EN
            err_par   <= 1'b0;
            par_bad   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A data byte waiting for its CRC expires after the gap.
                    if (phase) begin
                        if (gap_cnt == GAP_END) begin
                            phase   <= 1'b0;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    if (fall && enable) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end

                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (rx_sync) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                            if (!phase) begin
                                err_ovr <= 1'b0;
                                err_crc <= 1'b0;
                                err_frm <= 1'b0;
`ifdef COM_RX_PARITY_EN
                                err_par <= 1'b0;
`endif
                            end
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef COM_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

`ifdef COM_RX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                        par_bad <= ^{shreg, rx_sync};
                        if (^{shreg, rx_sync}) begin
                            err_par <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`endif

                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (!rx_sync) begin
                            err_frm <= 1'b1;
                            phase   <= 1'b0;
                            state   <= IDLE;
`ifdef COM_RX_PARITY_EN
                        end else if (par_bad) begin
                            phase <= 1'b0;
                            state <= IDLE;
`endif
                        end else if (!phase) begin
                            data_byte <= shreg;
                            phase     <= 1'b1;
                            gap_cnt   <= '0;
                            state     <= IDLE;
                        end else begin
                            state <= CHECK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                CHECK: begin
                    if (crc_ok) begin
                        state <= WRITE;
                    end else begin
                        err_crc <= 1'b1;
                        phase   <= 1'b0;
                        state   <= IDLE;
                    end
                end

                WRITE: begin
                    if (!fifo.fifo_busy) begin
                        if (fifo.fifo_full) begin
                            err_ovr <= 1'b1;
                        end else begin
                            last_sent <= data_byte;
                        end
                        phase <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_com_to_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_com_to_fifo                                             |
// | Description : Self-checking bench for com_to_fifo: reset values, a       |
// |               vector table of data/CRC pairs, multi-cycle corner cases   |
// |               and randomized pairs against a CRC model.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_com_to_fifo;

    localparam int CPB = 16;
`ifdef COM_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // rx fall -> 2 sync flops + edge compare (3), half bit to the start
    // sample, 8 data (+parity) + stop bits, then CHECK so that the strobe is
    // visible one cycle after the stop sample and accepted on the next edge.
    localparam int LAT = 3 + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       rx = 1'b1;
    logic       isFinish;
    logic [3:0] error;

    com_to_fifo_if fif ();

    com_to_fifo #(
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (255)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .rx       (rx),
        .fifo     (fif),
        .isFinish (isFinish),
        .error    (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle after the inputs driven on negedge.
    int         wr_cnt = 0;
    int         fin_cnt = 0;
    int         last_wr_cyc = 0;
    logic [7:0] last_wr_val = 8'h00;
    always begin
        @(negedge clk);
        #1;
        if (fif.fifo_we === 1'b1) begin
            wr_cnt++;
            last_wr_val = fif.forSent;
            last_wr_cyc = cyc;
        end
        if (isFinish === 1'b1) fin_cnt++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference CRC by polynomial long division of d*x^8 by 0x107.
    function automatic logic [7:0] model_crc(input logic [7:0] d);
        logic [15:0] r;
        r = {d, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        end
        return r[7:0];
    endfunction

    int last_start = 0;

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        last_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef COM_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic send_pair(input logic [7:0] d, input logic [7:0] c, input logic stop2);
        send_byte(d, 1'b1, 1'b0);
        send_byte(c, stop2, 1'b0);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [7:0] c;
        logic       stop2;
        int         exp_wr;
        logic [3:0] exp_err;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] exp_last = 8'h00;
    int         w0, f0, rel, kind;
    logic [7:0] rd, rc;
    logic       rs;

    initial begin : watchdog
        #(900000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h31, 8'h97, 1'b1, 1, 4'b0000};
        vecs[1] = '{8'hA5, 8'h73, 1'b1, 0, 4'b0100};
        vecs[2] = '{8'hA5, 8'h72, 1'b1, 1, 4'b0000};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 0, 4'b0001};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 1, 4'b0000};
        vecs[5] = '{8'h80, 8'h89, 1'b1, 1, 4'b0000};

        fif.fifo_busy = 1'b0;
        fif.fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_fifo_we", {31'd0, fif.fifo_we}, 32'd0);
        check("reset_isFinish", {31'd0, isFinish}, 32'd0);
        check("reset_forSent", {24'd0, fif.forSent}, 32'd0);
        check("reset_error", {28'd0, error}, 32'd0);
        reset = 1'b1;
        idle_bits(2);

        // Table of pairs.
        for (int v = 0; v < 6; v++) begin
            w0 = wr_cnt;
            f0 = fin_cnt;
            send_pair(vecs[v].d, vecs[v].c, vecs[v].stop2);
            idle_bits(3);
            if (vecs[v].exp_wr != 0) exp_last = vecs[v].d;
            check($sformatf("vec%0d_writes", v), wr_cnt - w0, vecs[v].exp_wr);
            check($sformatf("vec%0d_finish", v), fin_cnt - f0, vecs[v].exp_wr);
            check($sformatf("vec%0d_forSent", v), {24'd0, fif.forSent}, {24'd0, exp_last});
            check($sformatf("vec%0d_error", v), {28'd0, error}, {28'd0, vecs[v].exp_err});
        end

        // Latency from the CRC byte's start edge to the write strobe.
        send_pair(8'h31, 8'h97, 1'b1);
        idle_bits(2);
        exp_last = 8'h31;
        check("latency", last_wr_cyc - last_start, LAT);

        // Short glitch while flags are set: no false start, flags untouched.
        send_pair(8'hA5, 8'h73, 1'b1);
        idle_bits(2);
        w0 = wr_cnt;
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        idle_bits(3);
        check("glitch_error", {28'd0, error}, 32'h4);
        check("glitch_writes", wr_cnt - w0, 0);
        send_pair(8'h31, 8'h97, 1'b1);
        idle_bits(3);
        check("after_glitch_val", {24'd0, last_wr_val}, 32'h31);
        check("after_glitch_writes", wr_cnt - w0, 1);

        // FIFO busy for 10 cycles of WRITE.
        w0 = wr_cnt;
        fif.fifo_busy = 1'b1;
        send_pair(8'h5A, model_crc(8'h5A), 1'b1);
        rel = last_start + LAT + 10;
        wait_cyc(rel);
        fif.fifo_busy = 1'b0;
        idle_bits(2);
        exp_last = 8'h5A;
        check("busy_writes", wr_cnt - w0, 1);
        check("busy_write_cycle", last_wr_cyc, rel);
        check("busy_value", {24'd0, last_wr_val}, 32'h5A);

        // FIFO full: overrun flag, no write.
        w0 = wr_cnt;
        fif.fifo_full = 1'b1;
        send_pair(8'h3C, model_crc(8'h3C), 1'b1);
        idle_bits(3);
        fif.fifo_full = 1'b0;
        check("full_error", {28'd0, error}, 32'h8);
        check("full_writes", wr_cnt - w0, 0);
        check("full_forSent_hold", {24'd0, fif.forSent}, {24'd0, exp_last});

        // Gap timeout drops the lone data byte.
        w0 = wr_cnt;
        send_byte(8'h31, 1'b1, 1'b0);
        idle_bits(256);
        send_pair(8'h31, 8'h97, 1'b1);
        idle_bits(3);
        exp_last = 8'h31;
        check("gap_writes", wr_cnt - w0, 1);
        check("gap_value", {24'd0, last_wr_val}, 32'h31);
        check("gap_error", {28'd0, error}, 32'h0);

        // enable low: frames are ignored.
        enable = 1'b0;
        w0 = wr_cnt;
        send_pair(8'h44, model_crc(8'h44), 1'b1);
        idle_bits(3);
        enable = 1'b1;
        check("disabled_writes", wr_cnt - w0, 0);
        check("disabled_error", {28'd0, error}, 32'h0);

        // Reset during bit 4 of a data byte, with a flag set beforehand.
        send_pair(8'hA5, 8'h73, 1'b1);
        idle_bits(2);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_fifo_we", {31'd0, fif.fifo_we}, 32'd0);
        check("midreset_isFinish", {31'd0, isFinish}, 32'd0);
        check("midreset_forSent", {24'd0, fif.forSent}, 32'd0);
        check("midreset_error", {28'd0, error}, 32'd0);
        exp_last = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        idle_bits(4);
        w0 = wr_cnt;
        send_pair(8'h55, model_crc(8'h55), 1'b1);
        idle_bits(3);
        exp_last = 8'h55;
        check("postreset_writes", wr_cnt - w0, 1);
        check("postreset_value", {24'd0, last_wr_val}, 32'h55);
        check("postreset_error", {28'd0, error}, 32'h0);

        // Line already low at reset release must not start a frame.
        reset = 1'b0;
        rx = 1'b0;
        exp_last = 8'h00;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        w0 = wr_cnt;
        repeat (20 * CPB) @(negedge clk);
        idle_bits(3);
        check("lowline_error", {28'd0, error}, 32'h0);
        check("lowline_writes", wr_cnt - w0, 0);

`ifdef COM_RX_PARITY_EN
        // Wrong parity on the data byte.
        w0 = wr_cnt;
        send_byte(8'h31, 1'b1, 1'b1);
        send_byte(8'h97, 1'b1, 1'b0);
        idle_bits(3);
        check("parity_error", {28'd0, error}, 32'h2);
        check("parity_writes", wr_cnt - w0, 0);
`endif

        // Randomized pairs against the model.
        for (int n = 0; n < 16; n++) begin
            rd   = 8'($urandom);
            kind = $urandom_range(0, 9);
            rc   = model_crc(rd);
            rs   = 1'b1;
            if (kind == 7 || kind == 8) rc = rc ^ (8'h01 << $urandom_range(0, 7));
            if (kind == 9) rs = 1'b0;
            idle_bits($urandom_range(1, 8));
            w0 = wr_cnt;
            send_pair(rd, rc, rs);
            idle_bits(3);
            if (kind <= 6) begin
                exp_last = rd;
                check($sformatf("rnd%0d_writes", n), wr_cnt - w0, 1);
                check($sformatf("rnd%0d_error", n), {28'd0, error}, 32'h0);
            end else begin
                check($sformatf("rnd%0d_writes", n), wr_cnt - w0, 0);
                check($sformatf("rnd%0d_error", n), {28'd0, error}, (kind == 9) ? 32'h1 : 32'h4);
            end
            check($sformatf("rnd%0d_forSent", n), {24'd0, fif.forSent}, {24'd0, exp_last});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
